// File: rtl/svc_rv_io_pkg.sv
// rtl/svc_rv_io_pkg.sv - register offsets, field indices and write helper for the IO console/timer block
package svc_rv_io_pkg;

    localparam logic [2:0] IO_SCRATCH  = 3'd0;
    localparam logic [2:0] IO_CONSOLE  = 3'd1;
    localparam logic [2:0] IO_MTIME_LO = 3'd2;
    localparam logic [2:0] IO_MTIME_HI = 3'd3;
    localparam logic [2:0] IO_CMP_LO   = 3'd4;
    localparam logic [2:0] IO_CMP_HI   = 3'd5;
    localparam logic [2:0] IO_CTRL     = 3'd6;
    localparam logic [2:0] IO_STATUS   = 3'd7;

    localparam int STATUS_FULL      = 0;
    localparam int STATUS_EMPTY     = 1;
    localparam int STATUS_OVF       = 2;
    localparam int STATUS_COUNT_LSB = 8;

    localparam int CTRL_TIMER_EN = 0;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/svc_rv_io_console_timer_if.sv
// rtl/svc_rv_io_console_timer_if.sv - SoC IO bus plus console byte stream
interface svc_rv_io_console_timer_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0]   io_raddr;
    logic [XLEN-1:0]   io_rdata;
    logic              io_wen;
    logic [XLEN-1:0]   io_waddr;
    logic [XLEN-1:0]   io_wdata;
    logic [XLEN/8-1:0] io_wstrb;
    logic              cons_valid;
    logic [7:0]        cons_data;
    logic              cons_ready;

    modport master (
        output io_raddr, io_wen, io_waddr, io_wdata, io_wstrb, cons_ready,
        input  io_rdata, cons_valid, cons_data
    );

    modport slave (
        input  io_raddr, io_wen, io_waddr, io_wdata, io_wstrb, cons_ready,
        output io_rdata, cons_valid, cons_data
    );
endinterface

// File: rtl/svc_rv_io_fifo.sv
// rtl/svc_rv_io_fifo.sv - byte FIFO with extra-MSB pointers; a push into a full FIFO is taken when a pop coincides
module svc_rv_io_fifo #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        pop,
    output logic [7:0]  pop_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    logic [7:0] mem [2**AW];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        push_ok;
    logic        pop_ok;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count    = wptr - rptr;
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    // When full, the write slot is the head being popped; the head is read before the edge.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/svc_rv_io_console_timer.sv
// rtl/svc_rv_io_console_timer.sv - IO responder: scratch register, 64-bit timer with compare IRQ, console FIFO
module svc_rv_io_console_timer
    import svc_rv_io_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          FIFO_AW = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    svc_rv_io_console_timer_if.slave   bus,
    output logic                       timer_irq
);
    logic [31:0]      scratch;
    logic [63:0]      mtime;
    logic [63:0]      cmp;
    logic             timer_en;
    logic             ovf;
    logic             irq_q;
    logic [XLEN-1:0]  rdata_q;
    logic [31:0]      rd_val;
    logic [31:0]      status_val;

    logic             rd_hit;
    logic             wr_hit;
    logic [2:0]       roff;
    logic [2:0]       woff;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic [7:0]       fifo_head;
    logic             unused_addr_bits;

    assign rd_hit = (bus.io_raddr[31:5] == BASE[31:5]);
    assign wr_hit = bus.io_wen && (bus.io_waddr[31:5] == BASE[31:5]);
    assign roff   = bus.io_raddr[4:2];
    assign woff   = bus.io_waddr[4:2];
    assign unused_addr_bits = ^{bus.io_raddr[1:0], bus.io_waddr[1:0]};

    assign push = wr_hit && (woff == IO_CONSOLE) && bus.io_wstrb[0];
    assign pop  = bus.cons_ready && !fifo_empty;

    svc_rv_io_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.io_wdata[7:0]),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.cons_valid = !fifo_empty;
    assign bus.cons_data  = fifo_head;
    assign bus.io_rdata   = rdata_q;
    assign timer_irq      = irq_q;

    always_comb begin
        status_val = '0;
        status_val[STATUS_FULL]  = fifo_full;
        status_val[STATUS_EMPTY] = fifo_empty;
        status_val[STATUS_OVF]   = ovf;
        status_val[STATUS_COUNT_LSB +: 8] = {{(7 - FIFO_AW){1'b0}}, fifo_count};
    end

    always_comb begin
        rd_val = '0;
        if (rd_hit) begin
            case (roff)
                IO_SCRATCH:  rd_val = scratch;
                IO_CONSOLE:  rd_val = '0;
                IO_MTIME_LO: rd_val = mtime[31:0];
                IO_MTIME_HI: rd_val = mtime[63:32];
                IO_CMP_LO:   rd_val = cmp[31:0];
                IO_CMP_HI:   rd_val = cmp[63:32];
                IO_CTRL:     rd_val = {31'b0, timer_en};
                IO_STATUS:   rd_val = status_val;
                default:     rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch  <= '0;
            mtime    <= '0;
            cmp      <= '1;
            timer_en <= 1'b0;
            ovf      <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rdata_q <= rd_val;
            irq_q   <= timer_en && (mtime >= cmp);
            if (timer_en) mtime <= mtime + 64'd1;
            // A push into a full FIFO is only lost when no pop frees a slot the same cycle.
            if (push && fifo_full && !pop) ovf <= 1'b1;
            if (wr_hit) begin
                case (woff)
                    IO_SCRATCH: scratch <= apply_wstrb(scratch, bus.io_wdata, bus.io_wstrb);
                    IO_CMP_LO:  cmp[31:0]  <= apply_wstrb(cmp[31:0], bus.io_wdata, bus.io_wstrb);
                    IO_CMP_HI:  cmp[63:32] <= apply_wstrb(cmp[63:32], bus.io_wdata, bus.io_wstrb);
                    IO_CTRL:    if (bus.io_wstrb[0]) timer_en <= bus.io_wdata[CTRL_TIMER_EN];
                    IO_STATUS:  if (bus.io_wstrb[0] && bus.io_wdata[STATUS_OVF]) ovf <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_svc_rv_io_console_timer.sv
// tb/tb_svc_rv_io_console_timer.sv - directed self-checking bench for svc_rv_io_console_timer
module tb_svc_rv_io_console_timer;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk;
    logic rst_n;
    logic timer_irq;
    int   tests;
    int   fails;
    logic [31:0] rd;

    svc_rv_io_console_timer_if #(.XLEN(32)) bus();

    svc_rv_io_console_timer #(.XLEN(32), .BASE(BASE), .FIFO_AW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        bus.io_wen   = 1'b1;
        bus.io_waddr = a;
        bus.io_wdata = d;
        bus.io_wstrb = s;
        @(negedge clk);
        bus.io_wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.io_raddr = a;
        @(posedge clk);
        #1 d = bus.io_rdata;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.io_raddr   = '0;
        bus.io_wen     = 1'b0;
        bus.io_waddr   = '0;
        bus.io_wdata   = '0;
        bus.io_wstrb   = '0;
        bus.cons_ready = 1'b0;
        #12;
        check("reset_rdata", bus.io_rdata, 32'h0);
        check("reset_irq", {31'b0, timer_irq}, 32'h0);
        check("reset_valid", {31'b0, bus.cons_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        bus_read(BASE + 32'h10, rd); check("cmp_lo_reset", rd, 32'hFFFF_FFFF);
        bus_read(BASE + 32'h14, rd); check("cmp_hi_reset", rd, 32'hFFFF_FFFF);
        bus_read(BASE + 32'h1C, rd); check("status_reset", rd, 32'h0000_0002);
        bus_read(BASE + 32'h08, rd); check("mtime_lo_reset", rd, 32'h0);

        // Byte-strobed scratch write
        bus_write(BASE + 32'h00, 32'h1234_5678, 4'b0101);
        bus_read(BASE + 32'h00, rd); check("scratch_strb", rd, 32'h0034_0078);

        // Same-cycle read and write of scratch returns the old value
        @(negedge clk);
        bus.io_raddr = BASE;
        bus.io_wen   = 1'b1;
        bus.io_waddr = BASE;
        bus.io_wdata = 32'hFFFF_FFFF;
        bus.io_wstrb = 4'b1111;
        @(posedge clk);
        #1 check("scratch_same_cycle_old", bus.io_rdata, 32'h0034_0078);
        @(negedge clk);
        bus.io_wen = 1'b0;
        @(posedge clk);
        #1 check("scratch_new", bus.io_rdata, 32'hFFFF_FFFF);

        // Timer compare interrupt
        bus_write(BASE + 32'h14, 32'h0, 4'hF);
        bus_write(BASE + 32'h10, 32'd20, 4'hF);
        bus_read(BASE + 32'h18, rd); check("ctrl_reset", rd, 32'h0);
        check("irq_before_en", {31'b0, timer_irq}, 32'h0);
        bus_write(BASE + 32'h18, 32'h1, 4'hF);
        repeat (20) @(posedge clk);
        #1 check("irq_low_at_20", {31'b0, timer_irq}, 32'h0);
        @(posedge clk);
        #1 check("irq_high_at_21", {31'b0, timer_irq}, 32'h1);
        bus_write(BASE + 32'h10, 32'd1000, 4'hF);
        @(posedge clk);
        #1 check("irq_fall", {31'b0, timer_irq}, 32'h0);
        bus_read(BASE + 32'h0C, rd); check("mtime_hi", rd, 32'h0);
        bus_write(BASE + 32'h18, 32'h0, 4'hF);
        bus_read(BASE + 32'h18, rd); check("ctrl_cleared", rd, 32'h0);

        // Fill the console FIFO past capacity
        for (int i = 0; i < 17; i++) bus_write(BASE + 32'h04, 32'h41 + i, 4'b0001);
        bus_read(BASE + 32'h1C, rd); check("status_full_ovf", rd, 32'h0000_1005);
        check("head_stable", {24'b0, bus.cons_data}, 32'h41);
        check("valid_full", {31'b0, bus.cons_valid}, 32'h1);
        bus_read(BASE + 32'h04, rd); check("console_read_zero", rd, 32'h0);
        bus_write(BASE + 32'h1C, 32'h4, 4'b0001);
        bus_read(BASE + 32'h1C, rd); check("ovf_cleared", rd, 32'h0000_1001);

        // Push and pop together while full
        @(negedge clk);
        bus.io_wen     = 1'b1;
        bus.io_waddr   = BASE + 32'h04;
        bus.io_wdata   = 32'h60;
        bus.io_wstrb   = 4'b0001;
        bus.cons_ready = 1'b1;
        @(negedge clk);
        bus.io_wen     = 1'b0;
        bus.cons_ready = 1'b0;
        bus_read(BASE + 32'h1C, rd); check("full_push_pop", rd, 32'h0000_1001);

        // Drain: 0x42..0x50 then the late byte 0x60
        @(negedge clk);
        bus.cons_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_valid_%0d", i), {31'b0, bus.cons_valid}, 32'h1);
            check($sformatf("drain_data_%0d", i), {24'b0, bus.cons_data},
                  (i < 15) ? 32'h42 + i : 32'h60);
            @(negedge clk);
        end
        bus.cons_ready = 1'b0;
        check("drained_valid", {31'b0, bus.cons_valid}, 32'h0);
        bus_read(BASE + 32'h1C, rd); check("status_empty", rd, 32'h0000_0002);

        // Out-of-window accesses
        bus_write(BASE + 32'h20, 32'hDEAD_BEEF, 4'hF);
        bus_write(32'h0, 32'hDEAD_BEEF, 4'hF);
        bus_read(BASE + 32'h00, rd); check("miss_no_write", rd, 32'hFFFF_FFFF);
        bus_read(BASE + 32'h20, rd); check("miss_read_above", rd, 32'h0);
        bus_read(32'h0, rd); check("miss_read_zero", rd, 32'h0);

        // Asynchronous reset mid-operation
        bus_write(BASE + 32'h04, 32'h77, 4'b0001);
        bus.io_raddr = BASE;
        check("pre_reset_valid", {31'b0, bus.cons_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", {31'b0, bus.cons_valid}, 32'h0);
        check("async_rdata", bus.io_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(BASE + 32'h00, rd); check("post_reset_scratch", rd, 32'h0);
        bus_read(BASE + 32'h10, rd); check("post_reset_cmp", rd, 32'hFFFF_FFFF);
        bus_read(BASE + 32'h1C, rd); check("post_reset_status", rd, 32'h0000_0002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
